// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670-style pclk/vsync/href/byte-bus transmitter carrying an RGB565 test pattern.
// Every output except ov_pclk is registered and moves only on clk edges where ov_pclk falls.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        ov_pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  ov7670_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        busy
);
    localparam int LINE_T = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_T = 2 * H_ACTIVE;
    localparam int BAR_B  = H_ACTIVE / 4;
    localparam int LM1    = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
    localparam int LM2    = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
    localparam int LMAX   = LM1 > LM2 ? LM1 : LM2;
    localparam int CW     = $clog2(LINE_T);
    localparam int LW     = $clog2(LMAX + 1);
    localparam int BW     = $clog2(BAR_B);

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_T - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_B - 1);
    localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);
    localparam logic [LW-1:0] VA_LAST  = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST  = LW'(V_FRONT - 1);

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t        state_q, state_d, nxt;
    logic          pclk_q;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d, plast;
    logic [2:0]    bar_q, bar_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   solid_q, solid_d, pix;
    logic          vsync_q, vsync_d, href_q, href_d, done_q, done_d, busy_q, busy_d;
    logic [7:0]    data_q, data_d, cnt_q, cnt_d;
    logic          col_last, line_last, frame_end, start;

    assign plast = state_q == VSYNC  ? VS_LAST :
                   state_q == VBACK  ? VB_LAST :
                   state_q == ACTIVE ? VA_LAST : VF_LAST;
    assign nxt   = state_q == VSYNC  ? VBACK :
                   state_q == VBACK  ? ACTIVE :
                   state_q == ACTIVE ? VFRONT :
                   enable            ? VSYNC : IDLE;

    assign col_last  = col_q == COL_LAST;
    assign line_last = line_q == plast;
    assign frame_end = state_q == VFRONT && col_last && line_last;
    // Pattern inputs are captured whenever a frame begins, fresh or back-to-back.
    assign start     = enable && (state_q == IDLE || frame_end);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        bar_d   = bar_q;
        bcnt_d  = bcnt_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pix     = 16'h0000;
        if (pclk_q) begin
            if (state_q != IDLE) begin
                col_d  = col_last ? '0 : col_q + 1'b1;
                line_d = !col_last ? line_q : line_last ? '0 : line_q + 1'b1;
                if (col_last && line_last) state_d = nxt;
                if (frame_end) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end else if (enable) begin
                state_d = VSYNC;
            end
            if (start) begin
                pat_d   = pattern_sel;
                solid_d = solid_color;
            end
            // Bar index tracks the byte being presented, so no division by bar width is needed.
            bar_d   = col_d == '0 ? '0 : bcnt_q == BAR_LAST ? bar_q + 1'b1 : bar_q;
            bcnt_d  = (col_d == '0 || bcnt_q == BAR_LAST) ? '0 : bcnt_q + 1'b1;
            pix     = pat_q == 2'd0 ? BARS[bar_d] :
                      pat_q == 2'd1 ? {8'(line_d), 8'(col_d >> 1)} : solid_q;
            vsync_d = state_d == VSYNC;
            busy_d  = state_d != IDLE;
            href_d  = state_d == ACTIVE && int'(col_d) < HREF_T;
            data_d  = !href_d ? 8'h00 : col_d[0] ? pix[7:0] : pix[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pclk_q  <= 1'b0;
            col_q   <= '0;
            line_q  <= '0;
            bar_q   <= '0;
            bcnt_q  <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pclk_q  <= ~pclk_q;
            col_q   <= col_d;
            line_q  <= line_d;
            bar_q   <= bar_d;
            bcnt_q  <= bcnt_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ov_pclk     = pclk_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign ov7670_data = data_q;
    assign frame_done  = done_q;
    assign frame_cnt   = cnt_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: directed bench for the OV7670 stream generator at a small 16x4 geometry.
module tb_ov7670_stream_gen;
    localparam int N = 1200;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        ov_pclk, vsync, href, frame_done, busy;
    logic [7:0]  ov7670_data, frame_cnt;

    int n_cmp = 0, n_bad = 0;

    logic       s_vs [N], s_hr [N], s_pc [N], s_fd [N], s_bz [N];
    logic [7:0] s_d [N], s_cnt [N];
    logic [7:0] lb [4][32];
    int         ln [4];
    int         rise [8], wid [8];
    int         vr, vlen, nr, fd0, nfd, zviol;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    ov7670_stream_gen #(
        .H_ACTIVE(16), .V_ACTIVE(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .ov_pclk(ov_pclk), .vsync(vsync), .href(href), .ov7670_data(ov7670_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] p, input logic [15:0] c);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pattern_sel = p;
        solid_color = c;
        enable = 1'b1;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            s_vs[k] = vsync; s_hr[k] = href; s_pc[k] = ov_pclk; s_fd[k] = frame_done;
            s_bz[k] = busy;  s_d[k] = ov7670_data; s_cnt[k] = frame_cnt;
        end
    endtask

    task automatic analyse(input int n);
        vr = -1; vlen = 0; nr = 0; fd0 = -1; nfd = 0; zviol = 0;
        for (int i = 0; i < 8; i++) wid[i] = 0;
        for (int i = 0; i < 4; i++) ln[i] = 0;
        for (int k = 0; k < n; k++) begin
            if (s_vs[k] && vr < 0) vr = k;
            if (vr >= 0 && s_vs[k] && k - vr == vlen) vlen++;
            if (k > 0 && s_hr[k] && !s_hr[k-1]) begin
                if (nr < 8) rise[nr] = k;
                nr++;
            end
            if (s_hr[k] && nr > 0 && nr <= 8) wid[nr-1]++;
            if (s_fd[k]) begin
                if (fd0 < 0) fd0 = k;
                nfd++;
            end
            if (s_hr[k] && s_pc[k] && nr >= 1 && nr <= 4) begin
                if (ln[nr-1] < 32) lb[nr-1][ln[nr-1]] = s_d[k];
                ln[nr-1]++;
            end
            if (!s_hr[k] && s_d[k] !== 8'h00) zviol++;
        end
    endtask

    task automatic test_reset();
        logic prev;
        reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ov_pclk, vsync, href, ov7670_data, frame_done, frame_cnt, busy} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_hold: outputs=%h required 0",
                     {ov_pclk, vsync, href, ov7670_data, frame_done, frame_cnt, busy});
        end
        reset = 1'b0;
        prev = ov_pclk;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (ov_pclk !== ~prev) begin
                n_bad++;
                $display("FAIL idle_pclk_toggle[%0d]: pclk=%b required %b", i, ov_pclk, ~prev);
            end
            prev = ov_pclk;
            n_cmp++;
            if ({vsync, href, ov7670_data, frame_done, frame_cnt, busy} !== 20'd0) begin
                n_bad++;
                $display("FAIL idle_outputs[%0d]: outputs=%h required 0", i,
                         {vsync, href, ov7670_data, frame_done, frame_cnt, busy});
            end
        end
    endtask

    task automatic test_geometry();
        int bad_bytes;
        start(2'd2, 16'hABCD);
        capture(600);
        analyse(600);
        n_cmp++;
        if (vr < 0 || vr > 1) begin
            n_bad++;
            $display("FAIL start_latency: vsync rise sample=%0d required 0..1", vr);
        end
        n_cmp++;
        if (vlen !== 72) begin
            n_bad++;
            $display("FAIL vsync_width: got %0d clk required 72", vlen);
        end
        n_cmp++;
        if (nr !== 4) begin
            n_bad++;
            $display("FAIL href_count: got %0d required 4", nr);
        end
        n_cmp++;
        if (rise[0] - vr !== 144) begin
            n_bad++;
            $display("FAIL first_href_offset: got %0d clk required 144", rise[0] - vr);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wid[i] !== 64) begin
                n_bad++;
                $display("FAIL href_width[%0d]: got %0d required 64", i, wid[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (rise[i] - rise[i-1] !== 72) begin
                    n_bad++;
                    $display("FAIL href_spacing[%0d]: got %0d required 72", i, rise[i] - rise[i-1]);
                end
            end
        end
        n_cmp++;
        if (nfd !== 1 || fd0 - vr !== 504) begin
            n_bad++;
            $display("FAIL frame_done_timing: pulses=%0d offset=%0d required 1 and 504", nfd, fd0 - vr);
        end
        n_cmp++;
        if (fd0 < 0 || s_cnt[fd0] !== 8'd1 || s_vs[fd0] !== 1'b1 || s_bz[fd0] !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_end_state: cnt/vsync/busy=%h/%b/%b required 01/1/1",
                     fd0 < 0 ? 8'hxx : s_cnt[fd0], fd0 < 0 ? 1'bx : s_vs[fd0], fd0 < 0 ? 1'bx : s_bz[fd0]);
        end
        bad_bytes = 0;
        for (int l = 0; l < 4; l++) begin
            if (ln[l] != 32) bad_bytes++;
            for (int b = 0; b < 32 && b < ln[l]; b++)
                if (lb[l][b] !== (b[0] ? 8'hCD : 8'hAB)) bad_bytes++;
        end
        n_cmp++;
        if (bad_bytes != 0) begin
            n_bad++;
            $display("FAIL solid_bytes: %0d wrong bytes/lengths required 0", bad_bytes);
        end
        n_cmp++;
        if (zviol != 0) begin
            n_bad++;
            $display("FAIL data_zero_outside_href: %0d nonzero samples required 0", zviol);
        end
    endtask

    task automatic test_pattern1();
        int bad_bytes;
        logic [7:0] exp;
        start(2'd1, 16'hFFFF);
        capture(600);
        analyse(600);
        n_cmp++;
        if (ln[2] !== 32) begin
            n_bad++;
            $display("FAIL ramp_line_len: got %0d bytes required 32", ln[2]);
        end
        n_cmp++;
        if (lb[2][10] !== 8'h02 || lb[2][11] !== 8'h05) begin
            n_bad++;
            $display("FAIL ramp_y2_x5: got %h %h required 02 05", lb[2][10], lb[2][11]);
        end
        bad_bytes = 0;
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 32; b++) begin
                exp = b[0] ? 8'(b / 2) : 8'(l);
                if (lb[l][b] !== exp) bad_bytes++;
            end
        n_cmp++;
        if (bad_bytes != 0) begin
            n_bad++;
            $display("FAIL ramp_bytes: %0d wrong bytes required 0", bad_bytes);
        end
    endtask

    task automatic test_pattern0();
        int bad_bytes;
        logic [15:0] c;
        logic [7:0] exp;
        start(2'd0, 16'h1234);
        capture(600);
        analyse(600);
        n_cmp++;
        if (lb[0][4] !== 8'hFF || lb[0][5] !== 8'hE0 || lb[0][8] !== 8'h07 || lb[0][31] !== 8'h00) begin
            n_bad++;
            $display("FAIL bars_spot: got %h %h %h %h required FF E0 07 00",
                     lb[0][4], lb[0][5], lb[0][8], lb[0][31]);
        end
        bad_bytes = 0;
        for (int l = 0; l < 4; l++) begin
            if (ln[l] != 32) bad_bytes++;
            for (int b = 0; b < 32; b++) begin
                c = BARS[b / 4];
                exp = b[0] ? c[7:0] : c[15:8];
                if (lb[l][b] !== exp) bad_bytes++;
            end
        end
        n_cmp++;
        if (bad_bytes != 0) begin
            n_bad++;
            $display("FAIL bars_bytes: %0d wrong bytes/lengths required 0", bad_bytes);
        end
    endtask

    task automatic test_enable_drop();
        int dones, vrises;
        logic pv;
        start(2'd2, 16'h1234);
        dones = 0;
        vrises = 0;
        pv = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k == 200) enable = 1'b0;
            if (frame_done) dones++;
            if (vsync && !pv) vrises++;
            pv = vsync;
        end
        n_cmp++;
        if (dones !== 1 || vrises !== 1) begin
            n_bad++;
            $display("FAIL enable_drop_frames: done=%0d vsync_rises=%0d required 1 and 1", dones, vrises);
        end
        n_cmp++;
        if (busy !== 1'b0 || frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL enable_drop_idle: busy=%b cnt=%h required 0 01", busy, frame_cnt);
        end
        enable = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (vsync !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable_latency: vsync=%b busy=%b required 1 1", vsync, busy);
        end
    endtask

    task automatic test_reset_active();
        int k;
        logic seen_done;
        start(2'd1, 16'h0000);
        seen_done = 1'b0;
        k = 0;
        while (k < 1200 && !(seen_done && href)) begin
            tick();
            if (frame_done) seen_done = 1'b1;
            k++;
        end
        n_cmp++;
        if (!(seen_done && href) || frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL reach_second_active: done=%b href=%b cnt=%h required 1 1 01",
                     seen_done, href, frame_cnt);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({ov_pclk, vsync, href, ov7670_data, frame_done, frame_cnt, busy} !== 21'd0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: outputs=%h required 0",
                     {ov_pclk, vsync, href, ov7670_data, frame_done, frame_cnt, busy});
        end
        tick();
        reset = 1'b0;
        capture(600);
        analyse(600);
        n_cmp++;
        if (vr < 0 || vr > 1 || nr !== 4 || nfd !== 1 || fd0 - vr !== 504) begin
            n_bad++;
            $display("FAIL post_reset_frame: vr=%0d hrefs=%0d dones=%0d period=%0d required <=1 4 1 504",
                     vr, nr, nfd, fd0 - vr);
        end
        n_cmp++;
        if (fd0 < 0 || s_cnt[fd0] !== 8'd1 || lb[3][7] !== 8'h03) begin
            n_bad++;
            $display("FAIL post_reset_count: cnt=%h byte=%h required 01 03",
                     fd0 < 0 ? 8'hxx : s_cnt[fd0], lb[3][7]);
        end
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_pattern1();
        test_pattern0();
        test_enable_drop();
        test_reset_active();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

Synthesizable OV7670-compatible pixel-stream transmitter. It drives the `ov_pclk`/`vsync`/`href`/data bus exactly as the camera does, carrying a selectable RGB565 test pattern. It feeds the camera-capture path in place of the real sensor, for board bring-up without a camera and for closed-loop capture-to-HDMI simulation. It is the sending end of the camera parallel interface that the capture logic receives.

## Interface
- `H_ACTIVE`, default 640: active pixels per line. Must be a multiple of 8.
- `V_ACTIVE`, default 480: active lines per frame.
- `H_BLANK`, default 144: pclk periods with href low after each line's active bytes.
- `VSYNC_LINES`, default 3: lines with vsync high.
- `V_BACK`, default 17: blank lines after vsync.
- `V_FRONT`, default 10: blank lines after the last active line.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; frames run while high.
- `pattern_sel`  in  2  0 = colour bars, 1 = coordinate ramp, 2 = solid colour, 3 = solid colour.
- `solid_color`  in  16  RGB565 value used by pattern 2/3.
- `ov_pclk`  out  1  pixel clock, clk/2.
- `vsync`  out  1  active-high frame sync.
- `href`  out  1  active-high line valid.
- `ov7670_data`  out  8  byte bus.
- `frame_done`  out  1  one-clk pulse at the end of each frame.
- `frame_cnt`  out  8  completed-frame counter, wraps at 256.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Reset values: `ov_pclk`, `vsync`, `href`, `frame_done`, `busy` are 0; `ov7670_data` is 0x00; `frame_cnt` is 0x00; FSM is IDLE.
- `ov_pclk` free-runs, toggling every clk, in every state.
- All other outputs change only on "update edges": clk edges where `ov_pclk` goes 1→0. They are therefore stable at every `ov_pclk` rise.
- One tick = one pclk period = 2 clk. One line = LINE_T = 2·H_ACTIVE + H_BLANK ticks.
- FSM states: IDLE → VSYNC → VBACK → ACTIVE → VFRONT → VSYNC (or IDLE).
  - IDLE: `busy` is 0. At an update edge with `enable` = 1, enter VSYNC. At that same edge, latch `pattern_sel` and `solid_color` for the whole frame.
  - VSYNC: `vsync` = 1 for VSYNC_LINES·LINE_T ticks.
  - VBACK: all outputs low for V_BACK·LINE_T ticks.
  - ACTIVE: V_ACTIVE lines. Each line is `href` = 1 for 2·H_ACTIVE ticks, then `href` = 0 for H_BLANK ticks.
  - VFRONT: V_FRONT·LINE_T ticks. At its final update edge:
    - pulse `frame_done` for 1 clk;
    - increment `frame_cnt`;
    - go to VSYNC if `enable` = 1 (relatching pattern inputs), else go to IDLE.
- Deasserting `enable` mid-frame does not truncate the frame; the current frame completes.
- Byte order is RGB565 with the high byte first: byte 0 = pixel[15:8], byte 1 = pixel[7:0].
- `ov7670_data` = 0x00 whenever `href` = 0.
- x = pixel index 0..H_ACTIVE-1; y = active line 0..V_ACTIVE-1.
- Pattern 0, colour bars: 8 bars of H_ACTIVE/8 pixels each, colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index comes from a counter; no divider.
- Pattern 1, coordinate ramp: pixel = {y[7:0], x[7:0]}.
- Pattern 2/3, solid colour: pixel = latched `solid_color`.
- Counters are sized with `$clog2` of their maximum value; no counter overflows for legal parameters.

## Timing
- Start latency: `vsync` rises at the first update edge after `enable` goes high, i.e. ≤2 clk later.
- Each `href` high window is exactly 2·H_ACTIVE ticks (4·H_ACTIVE clk), and `href` edges coincide with `ov_pclk` falls.
- First `href` rise occurs (VSYNC_LINES + V_BACK)·LINE_T ticks after the `vsync` rise.
- Frame period is (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT)·LINE_T ticks.
- Back-to-back frames: `vsync` rises at the same update edge as `frame_done`, with no gap.
- Asynchronous `reset` mid-frame forces all outputs to their reset values immediately. Generation restarts from IDLE after release.

## Test plan
Use H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_T = 36 ticks and a 252-tick (504-clk) frame.
- Reset/idle: with `enable` = 0, `ov_pclk` toggles every clk, all other outputs hold 0, and `busy` = 0.
- Sync geometry: with `enable` = 1, `vsync` is high for 72 clk. The first `href` rise is 144 clk after the `vsync` rise. There are 4 `href` pulses of 64 clk each, spaced 72 clk apart. `frame_done` fires 504 clk after the `vsync` rise, and `frame_cnt` = 1.
- Pattern 1: a capture model sampling on `ov_pclk` rise sees line 2 pixel 5 as bytes 0x02, 0x05, and 32 bytes per line.
- Pattern 0: the sampled byte stream per line is FF FF FF FF FF E0 FF E0 07 FF … 00 00, i.e. 2 pixels per bar.
- Enable drop mid-frame: the frame completes, exactly one `frame_done` fires, and the FSM returns to IDLE with no further `vsync`. Re-enabling starts a fresh frame within 2 clk.
- Reset during ACTIVE: outputs are 0 immediately. After release and with `enable` = 1, a full correct frame follows and `frame_cnt` restarts from 0.
